// File: rtl/unpatchifier.sv
// unpatchifier
//   Reassembles a frame delivered in patch-major order (patch index, then
//   position inside the patch) into an internal frame buffer, then streams the
//   whole image back out in raster order. One frame buffer: IDLE -> LOAD ->
//   DRAIN -> IDLE.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   en                start a frame (only sampled in IDLE)
//   in_valid/in_ready input handshake; in_ready is high for the whole LOAD phase
//   in_pixel          patch-major input pixel
//   in_last           source's end-of-frame marker (checked, never trusted)
//   out_valid/out_ready output handshake; out_valid is high for the whole DRAIN phase
//   out_pixel         raster-order output pixel
//   out_last          high with the final raster pixel
//   state             IDLE=00, LOAD=01, DRAIN=10
//   frame_done        one-cycle pulse, first cycle back in IDLE
//   frame_err         sticky per frame: in_last disagreed with the pixel count
module unpatchifier #(
  parameter int CHANNEL_SIZE      = 8,
  parameter int NUM_CHANNELS      = 3,
  parameter int PIXEL_WIDTH       = CHANNEL_SIZE*NUM_CHANNELS,
  parameter int IMG_WIDTH         = 64,
  parameter int IMG_HEIGHT        = 64,
  parameter int PATCH_SIZE        = 16,
  parameter int PATCH_SIZE_LOG2   = 4,
  parameter int PATCHES_IN_ROW    = IMG_WIDTH/PATCH_SIZE,
  parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE),
  parameter int PATCH_VECTOR_SIZE = PATCH_SIZE*PATCH_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_last,
  output logic [1:0]             state,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int PATCH_ROWS = TOTAL_NUM_PATCHES / PATCHES_IN_ROW;
  localparam int QW  = 2*PATCH_SIZE_LOG2;
  localparam int PCW = (PATCHES_IN_ROW > 1) ? $clog2(PATCHES_IN_ROW) : 1;
  localparam int PRW = (PATCH_ROWS > 1) ? $clog2(PATCH_ROWS) : 1;
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int CW  = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, DRAIN = 2'b10} state_t;

  state_t st;

  // Load side: the patch index is kept as separate patch-row / patch-col
  // counters so the destination address needs only shifts and adds.
  logic [QW-1:0]  pq;
  logic [PCW-1:0] pc;
  logic [PRW-1:0] pr;
  logic [RW-1:0]  wr_row;
  logic [CW-1:0]  wr_col;

  // Drain side raster counters
  logic [RW-1:0]  r;
  logic [CW-1:0]  c;

  logic [PIXEL_WIDTH-1:0] fbuf [IMG_HEIGHT][IMG_WIDTH];

  logic last_pq, last_pc, last_pr, final_px;
  logic last_r, last_c;
  logic in_hs, out_hs;

  assign last_pq  = (pq == QW'(PATCH_VECTOR_SIZE-1));
  assign last_pc  = (pc == PCW'(PATCHES_IN_ROW-1));
  assign last_pr  = (pr == PRW'(PATCH_ROWS-1));
  assign final_px = last_pq && last_pc && last_pr;

  assign wr_row = (RW'(pr) << PATCH_SIZE_LOG2) + RW'(pq[QW-1:PATCH_SIZE_LOG2]);
  assign wr_col = (CW'(pc) << PATCH_SIZE_LOG2) + CW'(pq[PATCH_SIZE_LOG2-1:0]);

  assign last_r = (r == RW'(IMG_HEIGHT-1));
  assign last_c = (c == CW'(IMG_WIDTH-1));

  assign in_ready  = (st == LOAD);
  assign out_valid = (st == DRAIN);
  assign out_last  = out_valid && last_r && last_c;
  assign out_pixel = fbuf[r][c];
  assign state     = st;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Frame buffer: data only, never reset
  always_ff @(posedge clk) begin
    if (in_hs) fbuf[wr_row][wr_col] <= in_pixel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      pq         <= '0;
      pc         <= '0;
      pr         <= '0;
      r          <= '0;
      c          <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (st)
        IDLE: begin
          if (en) begin
            st        <= LOAD;
            frame_err <= 1'b0;
            pq        <= '0;
            pc        <= '0;
            pr        <= '0;
          end
        end
        LOAD: begin
          if (in_hs) begin
            // Frame length comes from the counters; in_last is only audited.
            if (in_last != final_px) frame_err <= 1'b1;
            if (last_pq) begin
              pq <= '0;
              if (last_pc) begin
                pc <= '0;
                pr <= last_pr ? '0 : pr + 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
            end else begin
              pq <= pq + 1'b1;
            end
            if (final_px) begin
              st <= DRAIN;
              r  <= '0;
              c  <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (last_c) begin
              c <= '0;
              r <= last_r ? '0 : r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
            if (out_last) begin
              st         <= IDLE;
              frame_done <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unpatchifier.sv
// Bench for unpatchifier: an 8x8 / 4x4-patch instance exercised with random
// stimulus against a scoreboard, plus a default-size 64x64 / 16 instance.
module tb_unpatchifier;
  localparam int W = 8, H = 8, PS = 4, L2 = 2;
  localparam int PIR = W/PS, NP = (W/PS)*(H/PS), PV = PS*PS, N = NP*PV;
  localparam int PW = 24;
  localparam int NB = 64*64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic en = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [PW-1:0] in_pixel = '0;
  logic in_ready, out_valid, out_last, frame_done, frame_err;
  logic [1:0] state;
  logic [PW-1:0] out_pixel;

  logic en_b = 1'b0, in_valid_b = 1'b0, in_last_b = 1'b0, out_ready_b = 1'b1;
  logic [PW-1:0] in_pixel_b = '0;
  logic in_ready_b, out_valid_b, out_last_b, frame_done_b, frame_err_b;
  logic [1:0] state_b;
  logic [PW-1:0] out_pixel_b;

  unpatchifier #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PATCH_SIZE(PS), .PATCH_SIZE_LOG2(L2)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_last(out_last), .state(state), .frame_done(frame_done),
    .frame_err(frame_err));

  unpatchifier dut_b (
    .clk(clk), .reset(reset), .en(en_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pixel(in_pixel_b), .in_last(in_last_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_pixel(out_pixel_b), .out_last(out_last_b), .state(state_b), .frame_done(frame_done_b),
    .frame_err(frame_err_b));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, n_out = 0, n_done = 0, ob = 0;
  bit stall_en = 1'b0;
  logic [PW:0]   exp_q[$];
  logic [PW-1:0] vals[N];
  logic [PW-1:0] img[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: place each patch-major pixel at its image position, then read raster.
  task automatic push_model();
    for (int k = 0; k < N; k++) begin
      int p, q, row, col;
      p = k / PV;
      q = k % PV;
      row = (p / PIR) * PS + q / PS;
      col = (p % PIR) * PS + q % PS;
      img[row*W + col] = vals[k];
    end
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N-1), img[i]});
  endtask

  // Random output backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor for the small instance
  initial begin
    bit prev_stall;
    logic [PW-1:0] prev_pix;
    logic prev_last;
    logic [PW:0] e;
    prev_stall = 1'b0;
    prev_pix = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid) chk("in_ready_in_drain", 32'(in_ready), 32'd0);
        if (prev_stall && out_valid) begin
          chk("stall_pixel_stable", 32'(out_pixel), 32'(prev_pix));
          chk("stall_last_stable", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_pixel), 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_pixel", 32'(out_pixel), 32'(e[PW-1:0]));
            chk("out_last", 32'(out_last), 32'(e[PW]));
          end
        end
        if (frame_done) n_done++;
        prev_stall = out_valid && !out_ready;
        prev_pix = out_pixel;
        prev_last = out_last;
      end
    end
  end

  // Monitor for the 64x64 instance: inverse mapping raster -> (patch, position)
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid_b && out_ready_b) begin
        int row, col, p, q;
        row = ob / 64;
        col = ob % 64;
        p = (row / 16) * 4 + col / 16;
        q = (row % 16) * 16 + col % 16;
        chk("b_out_pixel", 32'(out_pixel_b), 32'(p*256 + q));
        chk("b_out_last", 32'(out_last_b), 32'(ob == NB-1));
        ob++;
      end
    end
  end

  // Called at a negedge. pat: 0 -> k, 1 -> random, 2 -> 100+k.
  task automatic run_frame(input int pat, input bit gaps, input int early,
                           input bit final_last, input bit hold, input bit exp_err);
    int w, k, cyc, d;
    bit hs;
    for (int i = 0; i < N; i++)
      vals[i] = (pat == 0) ? PW'(i) : (pat == 1) ? PW'($urandom) : PW'(100 + i);
    push_model();
    en = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (state != 2'b01 && w < 10);
    chk("idle_to_load_latency", 32'(w), 32'd1);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("err_cleared_on_start", 32'(frame_err), 32'd0);
    if (!hold) en = 1'b0;
    @(posedge clk);
    #1;
    k = 0;
    cyc = 0;
    while (k < N && cyc < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_pixel = vals[k];
      in_last = (k == early) || (final_last && k == N-1);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) k++;
    end
    chk("pixels_accepted", 32'(k), 32'(N));
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    chk("load_to_drain_out_valid", 32'(out_valid), 32'd1);
    chk("load_to_drain_state", 32'(state), 32'd2);
    d = 0;
    do begin @(negedge clk); d++; end while (!frame_done && d < 3000);
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    chk("state_idle_at_done", 32'(state), 32'd0);
    chk("frame_err", 32'(frame_err), 32'(exp_err));
  endtask

  // Start a frame, load 20 pixels, then pulse reset mid-cycle.
  task automatic abort_frame();
    int w;
    en = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (state != 2'b01 && w < 10);
    chk("abort_enter_load", 32'(state), 32'd1);
    en = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_pixel = PW'(32'hABC000 + k);
      in_last = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_frame_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    int out0, d, w;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(0, 1'b0, -1, 1'b1, 1'b0, 1'b0);   // basic pattern
    stall_en = 1'b1;
    run_frame(0, 1'b1, -1, 1'b1, 1'b0, 1'b0);   // same frame, gaps + stalls
    run_frame(1, 1'b1, 10, 1'b1, 1'b0, 1'b1);   // early in_last
    stall_en = 1'b0;
    abort_frame();
    run_frame(2, 1'b0, -1, 1'b1, 1'b0, 1'b0);   // 100+k after abort
    out0 = n_out;
    run_frame(1, 1'b0, -1, 1'b1, 1'b1, 1'b0);   // back-to-back, en held
    run_frame(1, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    chk("back_to_back_outputs", 32'(n_out - out0), 32'd128);
    run_frame(1, 1'b1, -1, 1'b0, 1'b0, 1'b1);   // missing final in_last

    repeat (2) @(negedge clk);
    chk("frame_done_count", 32'(n_done), 32'd7);
    chk("total_outputs", 32'(n_out), 32'(7*N));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Default geometry 64x64 / 16
    en_b = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (state_b != 2'b01 && w < 10);
    chk("b_enter_load", 32'(state_b), 32'd1);
    en_b = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) begin
      in_valid_b = 1'b1;
      in_pixel_b = PW'(k);
      in_last_b = (k == NB-1);
      @(posedge clk);
      #1;
    end
    in_valid_b = 1'b0;
    in_last_b = 1'b0;
    d = 0;
    do begin @(negedge clk); d++; end while (!frame_done_b && d < 6000);
    chk("b_frame_done", 32'(frame_done_b), 32'd1);
    chk("b_output_count", 32'(ob), 32'(NB));
    chk("b_frame_err", 32'(frame_err_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
